// File: rtl/ad_tp_pkg.sv
// Shared constants for the multi-channel AD test-pattern source.
package ad_tp_pkg;

    localparam logic [7:0] TP_ID   = 8'd1;
    localparam logic [7:0] TP_RAMP = 8'd2;
    localparam logic [7:0] TP_FIX  = 8'd3;
    localparam logic [7:0] TP_PRBS = 8'd4;
    localparam logic [7:0] TP_TOG  = 8'd5;

    localparam int unsigned LFSR_W      = 23;
    localparam int unsigned LFSR_TAP_HI = 22;
    localparam int unsigned LFSR_TAP_LO = 17;

    localparam logic [7:0] TP_IDLE_BYTE = 8'h55;

    localparam int unsigned TP_CNT_W = 16;

endpackage

// File: rtl/ad_tp_chan.sv
// Per-channel pattern generator: owns the PRBS23 LFSR and forms the channel value.
module ad_tp_chan
    import ad_tp_pkg::*;
#(
    parameter int unsigned DW  = 24,
    parameter int unsigned NCH = 4
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              adv,
    input  logic [7:0]        mode,
    input  logic [1:0]        id_grp,
    input  logic [3:0]        ch_idx,
    input  logic [LFSR_W-1:0] seed_base,
    input  logic [DW-1:0]     ramp,
    input  logic [7:0]        ch_ofs,
    input  logic [DW-1:0]     fix,
    input  logic              tog,
    output logic [DW-1:0]     val_c
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;
    logic [LFSR_W-1:0] seed_c;
    logic [3:0]        id_nib_c;

    // Seed depends on channel so channels are decorrelated; all-zero would lock up.
    always_comb begin
        seed_c = seed_base ^ LFSR_W'(ch_idx + 4'd1);
        if (seed_c == '0) begin
            seed_c = LFSR_W'(1);
        end
    end

    // LFSR next state: reseed on restart, step once per processed tick.
    always_comb begin
        lfsr_d = lfsr_q;
        if (restart) begin
            lfsr_d = seed_c;
        end else if (adv) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
        end
    end

    // LFSR state register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_W'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Channel value for the selected mode.
    always_comb begin
        id_nib_c = ({2'b00, id_grp} * 4'(NCH)) + ch_idx + 4'd1;
        val_c    = DW'({(DW / 8 + 1){TP_IDLE_BYTE}});
        case (mode)
            TP_ID:   val_c = DW'({(DW / 4 + 1){id_nib_c}});
            TP_RAMP: val_c = ramp + DW'(12'(ch_idx) * 12'(ch_ofs));
            TP_FIX:  val_c = fix;
            TP_PRBS: val_c = DW'(lfsr_q);
            TP_TOG:  val_c = tog ? ~fix : fix;
            default: val_c = DW'({(DW / 8 + 1){TP_IDLE_BYTE}});
        endcase
    end

endmodule

// File: rtl/ad_tp_mc.sv
// Multi-channel test-pattern source: shared timebase, ramp/toggle state and
// valid/ready output stage feeding NCH per-channel generators.
module ad_tp_mc
    import ad_tp_pkg::*;
#(
    parameter int unsigned DW  = 24,
    parameter int unsigned NCH = 4,
    parameter int unsigned PW  = 24
) (
    input  logic                clk_sys,
    input  logic                rst_n,
    input  logic [5:0]          mod_id,
    input  logic                cfg_en,
    input  logic [7:0]          cfg_mode,
    input  logic [PW-1:0]       cfg_period,
    input  logic [DW-1:0]       cfg_base,
    input  logic [7:0]          cfg_step,
    input  logic [DW-1:0]       cfg_limit,
    input  logic [7:0]          cfg_ch_ofs,
    input  logic [DW-1:0]       cfg_fix,
    input  logic                cfg_ovf_clr,
    output logic [NCH*DW-1:0]   tp_data,
    output logic                tp_vld,
    input  logic                tp_rdy,
    output logic                tp_ovf,
    output logic [TP_CNT_W-1:0] tp_cnt
);

    localparam int unsigned RW = DW + 1;

    logic [7:0]          sh_mode_q,   sh_mode_d;
    logic [PW-1:0]       sh_per_q,    sh_per_d;
    logic [DW-1:0]       sh_base_q,   sh_base_d;
    logic [7:0]          sh_step_q,   sh_step_d;
    logic [DW-1:0]       sh_limit_q,  sh_limit_d;
    logic [7:0]          sh_ofs_q,    sh_ofs_d;
    logic                restart_q,   restart_d;
    logic [PW-1:0]       cnt_q,       cnt_d;
    logic                tick_q,      tick_d;
    logic [DW-1:0]       ramp_q,      ramp_d;
    logic                tog_q,       tog_d;
    logic [NCH*DW-1:0]   data_q,      data_d;
    logic                vld_q,       vld_d;
    logic                ovf_q,       ovf_d;
    logic [TP_CNT_W-1:0] tcnt_q,      tcnt_d;

    logic                restart_c;
    logic [PW-1:0]       per_c;
    logic                adv_c;
    logic                free_c;
    logic [RW-1:0]       ramp_nxt_c;
    logic [NCH*DW-1:0]   pat_c;
    logic [LFSR_W-1:0]   seed_base_c;
    logic                unused_mod_id;

    assign unused_mod_id = ^mod_id[5:2];
    assign seed_base_c   = LFSR_W'(cfg_base);

    // Restart detection, effective period and tick qualification.
    always_comb begin
        restart_c = restart_q
                  | (cfg_mode   != sh_mode_q)
                  | (cfg_period != sh_per_q)
                  | (cfg_base   != sh_base_q)
                  | (cfg_step   != sh_step_q)
                  | (cfg_limit  != sh_limit_q)
                  | (cfg_ch_ofs != sh_ofs_q);
        per_c      = (cfg_period < PW'(2)) ? PW'(2) : cfg_period;
        adv_c      = tick_q & ~restart_c;
        free_c     = ~vld_q | tp_rdy;
        ramp_nxt_c = {1'b0, ramp_q} + RW'(cfg_step);
    end

    // Next state: timebase, shared pattern state and output handshake.
    always_comb begin
        sh_mode_d  = cfg_mode;
        sh_per_d   = cfg_period;
        sh_base_d  = cfg_base;
        sh_step_d  = cfg_step;
        sh_limit_d = cfg_limit;
        sh_ofs_d   = cfg_ch_ofs;
        restart_d  = 1'b0;
        cnt_d      = cnt_q;
        tick_d     = 1'b0;
        ramp_d     = ramp_q;
        tog_d      = tog_q;
        data_d     = data_q;
        vld_d      = vld_q;
        ovf_d      = ovf_q;
        tcnt_d     = tcnt_q;

        if (restart_c || !cfg_en) begin
            cnt_d = '0;
        end else if (cnt_q >= per_c - PW'(1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + PW'(1);
        end

        if (restart_c) begin
            ramp_d = cfg_base;
            tog_d  = 1'b0;
        end else if (adv_c) begin
            tog_d = ~tog_q;
            if (ramp_nxt_c[DW] || ((cfg_limit != '0) && (ramp_nxt_c[DW-1:0] > cfg_limit))) begin
                ramp_d = cfg_base;
            end else begin
                ramp_d = ramp_nxt_c[DW-1:0];
            end
        end

        if (cfg_ovf_clr) begin
            ovf_d = 1'b0;
        end

        if (adv_c && free_c) begin
            data_d = pat_c;
            vld_d  = 1'b1;
            tcnt_d = tcnt_q + TP_CNT_W'(1);
        end else if (adv_c) begin
            ovf_d = 1'b1;
        end else if (vld_q && tp_rdy) begin
            vld_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sh_mode_q  <= '0;
            sh_per_q   <= '0;
            sh_base_q  <= '0;
            sh_step_q  <= '0;
            sh_limit_q <= '0;
            sh_ofs_q   <= '0;
            restart_q  <= 1'b1;
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            ramp_q     <= '0;
            tog_q      <= 1'b0;
            data_q     <= '0;
            vld_q      <= 1'b0;
            ovf_q      <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            sh_mode_q  <= sh_mode_d;
            sh_per_q   <= sh_per_d;
            sh_base_q  <= sh_base_d;
            sh_step_q  <= sh_step_d;
            sh_limit_q <= sh_limit_d;
            sh_ofs_q   <= sh_ofs_d;
            restart_q  <= restart_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            ramp_q     <= ramp_d;
            tog_q      <= tog_d;
            data_q     <= data_d;
            vld_q      <= vld_d;
            ovf_q      <= ovf_d;
            tcnt_q     <= tcnt_d;
        end
    end

    // One generator per channel.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        ad_tp_chan #(
            .DW  (DW),
            .NCH (NCH)
        ) u_chan (
            .clk_sys   (clk_sys),
            .rst_n     (rst_n),
            .restart   (restart_c),
            .adv       (adv_c),
            .mode      (cfg_mode),
            .id_grp    (mod_id[1:0]),
            .ch_idx    (4'(c)),
            .seed_base (seed_base_c),
            .ramp      (ramp_q),
            .ch_ofs    (cfg_ch_ofs),
            .fix       (cfg_fix),
            .tog       (tog_q),
            .val_c     (pat_c[c*DW +: DW])
        );
    end

    assign tp_data = data_q;
    assign tp_vld  = vld_q;
    assign tp_ovf  = ovf_q;
    assign tp_cnt  = tcnt_q;

endmodule

// File: tb/tb_ad_tp_mc.sv
// Self-checking bench for ad_tp_mc: table of pattern vectors plus hand-written
// cadence, backpressure, restart and reset sequences; transfers are scored.
module tb_ad_tp_mc;
    import ad_tp_pkg::*;

    localparam int unsigned DW  = 24;
    localparam int unsigned NCH = 4;
    localparam int unsigned PW  = 24;
    localparam int unsigned BW  = NCH * DW;

    logic                clk_sys = 1'b0;
    logic                rst_n;
    logic [5:0]          mod_id;
    logic                cfg_en;
    logic [7:0]          cfg_mode;
    logic [PW-1:0]       cfg_period;
    logic [DW-1:0]       cfg_base;
    logic [7:0]          cfg_step;
    logic [DW-1:0]       cfg_limit;
    logic [7:0]          cfg_ch_ofs;
    logic [DW-1:0]       cfg_fix;
    logic                cfg_ovf_clr;
    logic [BW-1:0]       tp_data;
    logic                tp_vld;
    logic                tp_rdy;
    logic                tp_ovf;
    logic [TP_CNT_W-1:0] tp_cnt;

    ad_tp_mc #(.DW(DW), .NCH(NCH), .PW(PW)) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .mod_id      (mod_id),
        .cfg_en      (cfg_en),
        .cfg_mode    (cfg_mode),
        .cfg_period  (cfg_period),
        .cfg_base    (cfg_base),
        .cfg_step    (cfg_step),
        .cfg_limit   (cfg_limit),
        .cfg_ch_ofs  (cfg_ch_ofs),
        .cfg_fix     (cfg_fix),
        .cfg_ovf_clr (cfg_ovf_clr),
        .tp_data     (tp_data),
        .tp_vld      (tp_vld),
        .tp_rdy      (tp_rdy),
        .tp_ovf      (tp_ovf),
        .tp_cnt      (tp_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [7:0]    mode;
        logic [DW-1:0] base;
        logic [PW-1:0] period;
        logic [DW-1:0] fix;
        logic [7:0]    step;
        logic [7:0]    ofs;
        logic [DW-1:0] limit;
        logic [5:0]    id;
        logic [BW-1:0] e0;
        logic [BW-1:0] e1;
        logic [BW-1:0] e2;
    } vec_t;

    vec_t          vt[6];
    logic [BW-1:0] sb[$];
    int            checks  = 0;
    int            errors  = 0;
    int            exp_cnt = 0;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic wait_vld(input int max_e, output int k);
        k = 0;
        do begin
            @(posedge clk_sys);
            #1;
            k++;
        end while (!tp_vld && k < max_e);
    endtask

    task automatic push(input logic [BW-1:0] e);
        sb.push_back(e);
        exp_cnt++;
    endtask

    task automatic apply(input logic [7:0] m, input logic [DW-1:0] b, input logic [PW-1:0] p,
                         input logic [7:0] s, input logic [DW-1:0] l, input logic [7:0] o,
                         input logic [DW-1:0] f);
        cfg_mode   = m;
        cfg_base   = b;
        cfg_period = p;
        cfg_step   = s;
        cfg_limit  = l;
        cfg_ch_ofs = o;
        cfg_fix    = f;
    endtask

    // Score every transfer against the oldest expected sample.
    always @(negedge clk_sys) begin
        if (rst_n && tp_vld && tp_rdy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected act=%h exp=none", tp_data);
            end else begin
                chk("sb_data", tp_data, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int p;
        logic [BW-1:0] e;

        vt[0] = '{TP_PRBS, 24'h0, 24'd0, 24'h0, 8'd0, 8'd0, 24'h0, 6'h00,
                  {24'h4, 24'h3, 24'h2, 24'h1}, {24'h8, 24'h6, 24'h4, 24'h2},
                  {24'h10, 24'hC, 24'h8, 24'h4}};
        vt[1] = '{TP_ID, 24'h0, 24'd2, 24'h0, 8'd0, 8'd0, 24'h0, 6'h3E,
                  {24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA, 24'h999999},
                  {24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA, 24'h999999},
                  {24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA, 24'h999999}};
        vt[2] = '{TP_FIX, 24'h0, 24'd3, 24'h123456, 8'd0, 8'd0, 24'h0, 6'h00,
                  {4{24'h123456}}, {4{24'h123456}}, {4{24'h123456}}};
        vt[3] = '{8'h77, 24'h0, 24'd1, 24'h0, 8'd0, 8'd0, 24'h0, 6'h00,
                  {12{8'h55}}, {12{8'h55}}, {12{8'h55}}};
        vt[4] = '{TP_TOG, 24'h0, 24'd5, 24'h00F0F0, 8'd0, 8'd0, 24'h0, 6'h00,
                  {4{24'h00F0F0}}, {4{24'hFF0F0F}}, {4{24'h00F0F0}}};
        vt[5] = '{TP_RAMP, 24'hFFFFFE, 24'd2, 24'h0, 8'd1, 8'h10, 24'h0, 6'h00,
                  {24'h00002E, 24'h00001E, 24'h00000E, 24'hFFFFFE},
                  {24'h00002F, 24'h00001F, 24'h00000F, 24'hFFFFFF},
                  {24'h00002E, 24'h00001E, 24'h00000E, 24'hFFFFFE}};

        // Reset values.
        rst_n       = 1'b0;
        mod_id      = 6'h00;
        cfg_en      = 1'b1;
        cfg_ovf_clr = 1'b0;
        tp_rdy      = 1'b1;
        apply(TP_RAMP, 24'h10, 24'd4, 8'd2, 24'h14, 8'd1, 24'h0);
        step(3);
        chk("rst_data", tp_data, '0);
        chk("rst_vld", BW'(tp_vld), '0);
        chk("rst_ovf", BW'(tp_ovf), '0);
        chk("rst_cnt", BW'(tp_cnt), '0);

        // Ramp with limit wrap and per-channel offset; cadence after forced restart.
        push({24'h13, 24'h12, 24'h11, 24'h10});
        push({24'h15, 24'h14, 24'h13, 24'h12});
        push({24'h17, 24'h16, 24'h15, 24'h14});
        push({24'h13, 24'h12, 24'h11, 24'h10});
        rst_n = 1'b1;
        step(1);
        chk("ramp_vld_e0", BW'(tp_vld), '0);
        for (int i = 1; i <= 17; i++) begin
            step(1);
            chk($sformatf("ramp_vld_e%0d", i), BW'(tp_vld), BW'((i >= 5) && (i % 4 == 1)));
        end
        cfg_en = 1'b0;
        step(3);
        chk("ramp_drain", BW'(sb.size()), '0);

        // Pattern vector table.
        for (int v = 0; v < 6; v++) begin
            apply(vt[v].mode, vt[v].base, vt[v].period, vt[v].step, vt[v].limit,
                  vt[v].ofs, vt[v].fix);
            mod_id = vt[v].id;
            cfg_en = 1'b1;
            tp_rdy = 1'b1;
            push(vt[v].e0);
            push(vt[v].e1);
            push(vt[v].e2);
            p = (vt[v].period < 2) ? 2 : int'(vt[v].period);
            step(1);
            wait_vld(p + 20, k);
            chk($sformatf("v%0d_first", v), BW'(k), BW'(p + 1));
            for (int j = 1; j < 3; j++) begin
                wait_vld(p + 20, k);
                chk($sformatf("v%0d_gap%0d", v, j), BW'(k), BW'(p));
            end
            cfg_en = 1'b0;
            step(3);
            chk($sformatf("v%0d_drain", v), BW'(sb.size()), '0);
        end

        // Backpressure: hold, drop two ticks, tick coinciding with transfer.
        apply(TP_RAMP, 24'h100, 24'd4, 8'd1, 24'h0, 8'd0, 24'h0);
        cfg_en = 1'b1;
        tp_rdy = 1'b0;
        push({4{24'h100}});
        step(1);
        wait_vld(20, k);
        chk("bp_first", BW'(k), BW'(5));
        chk("bp_ovf_pre", BW'(tp_ovf), '0);
        step(8);
        chk("bp_hold_vld", BW'(tp_vld), BW'(1));
        chk("bp_hold_data", tp_data, {4{24'h100}});
        chk("bp_ovf", BW'(tp_ovf), BW'(1));
        chk("bp_cnt", BW'(tp_cnt), BW'(exp_cnt));
        step(3);
        tp_rdy = 1'b1;
        push({4{24'h103}});
        step(1);
        cfg_en = 1'b0;
        chk("bp_reload_vld", BW'(tp_vld), BW'(1));
        chk("bp_reload_data", tp_data, {4{24'h103}});
        chk("bp_reload_cnt", BW'(tp_cnt), BW'(exp_cnt));
        step(1);
        chk("bp_done_vld", BW'(tp_vld), '0);
        chk("bp_ovf_sticky", BW'(tp_ovf), BW'(1));
        cfg_ovf_clr = 1'b1;
        step(1);
        cfg_ovf_clr = 1'b0;
        chk("bp_ovf_clr", BW'(tp_ovf), '0);

        // Step change with a sample pending: sample kept, ramp and cadence restart.
        apply(TP_RAMP, 24'h40, 24'd4, 8'd4, 24'h0, 8'd0, 24'h0);
        cfg_en = 1'b1;
        tp_rdy = 1'b0;
        push({4{24'h40}});
        step(1);
        wait_vld(20, k);
        chk("sc_first", BW'(k), BW'(5));
        step(1);
        cfg_step = 8'd8;
        step(1);
        chk("sc_pend_vld", BW'(tp_vld), BW'(1));
        chk("sc_pend_data", tp_data, {4{24'h40}});
        tp_rdy = 1'b1;
        push({4{24'h40}});
        push({4{24'h48}});
        for (int i = 1; i <= 5; i++) begin
            step(1);
            chk($sformatf("sc_vld_e%0d", i), BW'(tp_vld), BW'(i == 5));
        end
        wait_vld(20, k);
        chk("sc_gap", BW'(k), BW'(4));
        cfg_en = 1'b0;
        step(3);
        chk("sc_ovf", BW'(tp_ovf), '0);
        chk("sc_drain", BW'(sb.size()), '0);

        // Asynchronous reset with a sample pending, then toggle after forced restart.
        apply(TP_TOG, 24'h0, 24'd3, 8'd0, 24'h0, 8'd0, 24'h00F0F0);
        cfg_en = 1'b1;
        tp_rdy = 1'b0;
        push({4{24'h00F0F0}});
        step(1);
        wait_vld(20, k);
        chk("ar_first", BW'(k), BW'(4));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_data", tp_data, '0);
        chk("ar_vld", BW'(tp_vld), '0);
        chk("ar_ovf", BW'(tp_ovf), '0);
        chk("ar_cnt", BW'(tp_cnt), '0);
        sb.delete();
        exp_cnt = 0;
        @(posedge clk_sys);
        #1;
        rst_n  = 1'b1;
        tp_rdy = 1'b1;
        push({4{24'h00F0F0}});
        push({4{24'hFF0F0F}});
        step(1);
        wait_vld(20, k);
        chk("ar_restart_first", BW'(k), BW'(4));
        chk("ar_restart_cnt", BW'(tp_cnt), BW'(1));
        wait_vld(20, k);
        chk("ar_restart_gap", BW'(k), BW'(3));
        cfg_en = 1'b0;
        step(3);
        chk("ar_drain", BW'(sb.size()), '0);
        e = {4{24'hFF0F0F}};
        chk("ar_last_data", tp_data, e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad_tp_mc.md
Name: ad_tp_mc

Overview:
Parametrised multi-channel successor to the AD-front-end test-pattern source: one shared period timebase drives NCH independent per-channel pattern generators.
Adds a programmable period, ramp limit with wrap, PRBS23 and toggle modes, and per-channel ramp offset.
Adds a valid/ready output handshake with overflow detection and a sample counter.
Sits in ad_top in place of the live AD data path when test mode is selected; output feeds the sample packer.

Parameters:
DW, 24, sample width per channel (>=8)
NCH, 4, channel count (1..8)
PW, 24, period counter width

Ports:
clk_sys  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
mod_id  in  6  module id; [1:0] used by ID mode
cfg_en  in  1  1 = timebase runs
cfg_mode  in  8  pattern mode, see Behaviour
cfg_period  in  PW  sample period in clk_sys cycles; values 0/1 treated as 2
cfg_base  in  DW  ramp start value; PRBS seed
cfg_step  in  8  ramp increment, zero-extended
cfg_limit  in  DW  ramp upper limit; 0 = no limit
cfg_ch_ofs  in  8  per-channel ramp offset
cfg_fix  in  DW  fixed / toggle value
cfg_ovf_clr  in  1  pulse, clears tp_ovf
tp_data  out  NCH*DW  channel c at [c*DW +: DW]
tp_vld  out  1  sample valid
tp_rdy  in  1  downstream ready
tp_ovf  out  1  sticky: a tick was dropped
tp_cnt  out  16  accepted-into-output sample count, wraps

Behaviour:
- Reset values: tp_data=0, tp_vld=0, tp_ovf=0, tp_cnt=0, period counter=0, shadow cfg regs=0. A restart flag resets to 1, forcing a restart on the first clock after reset.
- Restart: registered shadows of cfg_mode/period/base/step/limit/ch_ofs are compared with the inputs. Any difference, or the restart flag, causes the following on that edge:
  - cnt <= 0
  - ramp <= cfg_base
  - LFSRs reseeded
  - toggle phase <= 0
  - pending output sample is kept.
- Timebase:
  - cnt counts 0..P-1, with P = max(cfg_period, 2).
  - tick = cfg_en & (cnt == P-1).
  - cfg_en=0 holds cnt at 0.
- Tick processing, same edge:
  - If output is free, i.e. ~tp_vld | tp_rdy: tp_data <= current pattern values, tp_vld <= 1, tp_cnt++.
  - Else: sample dropped, tp_ovf <= 1.
  - In both cases the pattern state advances.
- Handshake:
  - Transfer = tp_vld & tp_rdy.
  - tp_data is stable while tp_vld & ~tp_rdy.
  - On transfer without tick: tp_vld <= 0.
  - Tick coinciding with transfer: new sample loaded, tp_vld stays 1, no overflow.
- First tp_vld rises P+1 edges after the restart edge; one tick per P cycles thereafter.
- cfg_ovf_clr clears tp_ovf. If a drop occurs in the same cycle, the set wins.
- Modes (value of channel c, c = 0..NCH-1):
  - 1 ID: every nibble = (mod_id[1:0]*NCH + c + 1)[3:0].
  - 2 RAMP:
    - Value = ramp + c*cfg_ch_ofs, mod 2^DW.
    - Advance: nxt = ramp + step, DW+1 bits.
    - ramp <= cfg_base if carry, or if cfg_limit != 0 and nxt > cfg_limit (unsigned); else ramp <= nxt.
  - 3 FIXED: cfg_fix.
  - 4 PRBS23:
    - Per-channel 23-bit Fibonacci LFSR, new bit = s[22]^s[17], shift left, insert at bit 0.
    - Seed = cfg_base[22:0] ^ (c+1); an all-zero seed becomes 1.
    - Output = s zero-extended or truncated to DW.
  - 5 TOGGLE: phase 0 gives cfg_fix, phase 1 gives ~cfg_fix; phase flips per tick. Value is identical on all channels.
  - Other values: every byte 0x55.
- Mode change mid-stream goes through restart; the pending sample is not corrupted.
- Asynchronous reset mid-transfer: all outputs return to reset values immediately.

Decomposition:
- Package ad_tp_pkg holds:
  - mode constants TP_ID=1, TP_RAMP=2, TP_FIX=3, TP_PRBS=4, TP_TOG=5
  - LFSR width 23 and taps 22/17
  - idle byte 8'h55
  - tp_cnt width 16
- Sub-module ad_tp_chan, one per channel via generate, holds the per-channel generator: LFSR, channel index input, and value output.
- Shared ramp/toggle state, the timebase and the handshake stay in ad_tp_mc.

Test Plan:
- NCH=2, RAMP, base=0x10, step=2, limit=0x14, ofs=1, P=4, tp_rdy=1 -> ch0 0x10,0x12,0x14,0x10,...; ch1 0x11,0x13,0x15,0x11; tp_vld 1-cycle pulses at edges 5, 9, 13 after restart.
- PRBS, base=0, P=2 -> ch0 0x000001, 0x000002, 0x000004; ch1 seeded 2 gives 0x000002, 0x000004.
- ID mode, mod_id=2, NCH=4 -> ch0 0x999999, ch1 0xAAAAAA, ch2 0xBBBBBB, ch3 0xCCCCCC.
- Backpressure: tp_rdy=0 over 3 ticks -> first sample held stable, tp_ovf=1, tp_cnt=1. Then tp_rdy=1 on a tick edge -> 4th-tick data loaded, tp_vld stays 1. cfg_ovf_clr -> tp_ovf=0.
- Change cfg_step mid-ramp while a sample is pending -> pending sample unchanged; next sample = cfg_base; cadence restarts.
- rst_n low mid-stream -> all outputs 0 asynchronously. After release, a forced restart occurs; TOGGLE with cfg_fix=0x00F0F0 gives 0x00F0F0, then 0xFF0F0F.
